reorder_buffer: RTL and testbench

REORDER_BUFFER -- requirements
Module: reorder_buffer

---
 rtl/reorder_buffer_pkg.sv | 24 ++
 rtl/reorder_buffer.sv | 199 +++++++++++++++++++
 tb/tb_reorder_buffer.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reorder_buffer_pkg.sv
// Shared definitions for the reorder buffer: bus widths, depth and entry-type encodings.
package reorder_buffer_pkg;

    localparam int unsigned ROB_SIZE = 16;
    localparam int unsigned TagW     = 4;
    localparam int unsigned RegW     = 5;
    localparam int unsigned DataW    = 32;
    localparam int unsigned CountW   = 5;

    typedef logic [TagW-1:0]  TagBus;
    typedef logic [RegW-1:0]  RegBus;
    typedef logic [DataW-1:0] DataBus;

    localparam logic   Valid   = 1'b1;
    localparam logic   Invalid = 1'b0;
    localparam DataBus Null    = '0;

    typedef enum logic [1:0] {
        TypeNormal = 2'd0,
        TypeBranch = 2'd1,
        TypeStore  = 2'd2
    } rob_type_e;

endpackage

// File: rtl/reorder_buffer.sv
// Reorder buffer: 16-entry in-order commit queue with CDB completion and mispredict flush.
// Define ROB_BYPASS_EN to serve operand lookups on the query ports; otherwise they read as zero.
module reorder_buffer
    import reorder_buffer_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             ID_valid,
    input  logic [1:0]       ID_type,
    input  logic [RegW-1:0]  ID_reg_dest,
    input  logic [DataW-1:0] ID_pc,
    output logic             ROB_full,
    output logic [TagW-1:0]  ROB_next_tag,
    input  logic             CDB_valid,
    input  logic [TagW-1:0]  CDB_tag,
    input  logic [DataW-1:0] CDB_data,
    input  logic             CDB_mispredict,
    input  logic [DataW-1:0] CDB_target_pc,
    output logic             ROB_data_valid,
    output logic [RegW-1:0]  ROB_reg_dest,
    output logic [TagW-1:0]  ROB_tag,
    output logic [DataW-1:0] ROB_data,
    output logic             LSB_commit_valid,
    output logic [TagW-1:0]  LSB_commit_tag,
    output logic             clear,
    output logic [DataW-1:0] clear_pc,
    input  logic [TagW-1:0]  query1_tag,
    output logic             query1_ready,
    output logic [DataW-1:0] query1_data,
    input  logic [TagW-1:0]  query2_tag,
    output logic             query2_ready,
    output logic [DataW-1:0] query2_data
);

    rob_type_e type_q   [ROB_SIZE];
    rob_type_e type_d   [ROB_SIZE];
    RegBus     dest_q   [ROB_SIZE];
    RegBus     dest_d   [ROB_SIZE];
    DataBus    data_q   [ROB_SIZE];
    DataBus    data_d   [ROB_SIZE];
    DataBus    target_q [ROB_SIZE];
    DataBus    target_d [ROB_SIZE];
    logic [ROB_SIZE-1:0][DataW-1:0] pc_q, pc_d;
    logic [ROB_SIZE-1:0] ready_q, ready_d, mis_q, mis_d;
    TagBus               head_q, head_d, tail_q, tail_d;
    logic [CountW-1:0]   count_q, count_d;

    logic   dv_q, dv_d, lsb_q, lsb_d, clear_q, clear_d;
    RegBus  rdest_q, rdest_d;
    TagBus  rtag_q, rtag_d, lsb_tag_q, lsb_tag_d;
    DataBus rdata_q, rdata_d, clear_pc_q, clear_pc_d;

    logic      full, alloc, complete, commit, flush;
    rob_type_e head_type;

    // Entry PCs are recorded for debug visibility; no output consumes them.
    logic unused_pc;
    assign unused_pc = ^pc_q;

    always_comb begin
        full      = (count_q == CountW'(ROB_SIZE));
        alloc     = rdy && !clear_q && ID_valid && !full;
        complete  = rdy && !clear_q && CDB_valid;
        commit    = rdy && (count_q != '0) && ready_q[head_q];
        head_type = type_q[head_q];
        flush     = commit && (head_type == TypeBranch) && mis_q[head_q];
    end

    always_comb begin
        type_d   = type_q;
        dest_d   = dest_q;
        data_d   = data_q;
        target_d = target_q;
        pc_d     = pc_q;
        ready_d  = ready_q;
        mis_d    = mis_q;
        head_d   = head_q;
        tail_d   = tail_q;
        if (alloc) begin
            type_d[tail_q]  = rob_type_e'(ID_type);
            dest_d[tail_q]  = ID_reg_dest;
            pc_d[tail_q]    = ID_pc;
            ready_d[tail_q] = 1'b0;
            mis_d[tail_q]   = 1'b0;
            tail_d          = tail_q + TagBus'(1);
        end
        if (complete) begin
            ready_d[CDB_tag]  = 1'b1;
            data_d[CDB_tag]   = CDB_data;
            mis_d[CDB_tag]    = CDB_mispredict;
            target_d[CDB_tag] = CDB_target_pc;
        end
        if (commit) begin
            head_d = head_q + TagBus'(1);
        end
        count_d = count_q + CountW'(alloc) - CountW'(commit);
        // A mispredicted branch squashes everything younger, including this edge's alloc.
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            ready_d = '0;
            mis_d   = '0;
        end
    end

    always_comb begin
        dv_d       = commit && (head_type != TypeStore);
        lsb_d      = commit && (head_type == TypeStore);
        clear_d    = flush;
        rdest_d    = commit ? dest_q[head_q] : rdest_q;
        rtag_d     = commit ? head_q         : rtag_q;
        rdata_d    = commit ? data_q[head_q] : rdata_q;
        lsb_tag_d  = commit ? head_q         : lsb_tag_q;
        clear_pc_d = flush  ? target_q[head_q] : clear_pc_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            type_q     <= '{default: TypeNormal};
            dest_q     <= '{default: '0};
            data_q     <= '{default: '0};
            target_q   <= '{default: '0};
            pc_q       <= '0;
            ready_q    <= '0;
            mis_q      <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            dv_q       <= 1'b0;
            lsb_q      <= 1'b0;
            clear_q    <= 1'b0;
            rdest_q    <= '0;
            rtag_q     <= '0;
            rdata_q    <= '0;
            lsb_tag_q  <= '0;
            clear_pc_q <= '0;
        end else begin
            dv_q       <= dv_d;
            lsb_q      <= lsb_d;
            clear_q    <= clear_d;
            rdest_q    <= rdest_d;
            rtag_q     <= rtag_d;
            rdata_q    <= rdata_d;
            lsb_tag_q  <= lsb_tag_d;
            clear_pc_q <= clear_pc_d;
            if (rdy) begin
                type_q   <= type_d;
                dest_q   <= dest_d;
                data_q   <= data_d;
                target_q <= target_d;
                pc_q     <= pc_d;
                ready_q  <= ready_d;
                mis_q    <= mis_d;
                head_q   <= head_d;
                tail_q   <= tail_d;
                count_q  <= count_d;
            end
        end
    end

    assign ROB_full         = full;
    assign ROB_next_tag     = tail_q;
    assign ROB_data_valid   = dv_q;
    assign ROB_reg_dest     = rdest_q;
    assign ROB_tag          = rtag_q;
    assign ROB_data         = rdata_q;
    assign LSB_commit_valid = lsb_q;
    assign LSB_commit_tag   = lsb_tag_q;
    assign clear            = clear_q;
    assign clear_pc         = clear_pc_q;

`ifdef ROB_BYPASS_EN
    // A same-cycle CDB broadcast wins over the stored entry so dispatch never misses it.
    always_comb begin
        query1_ready = ready_q[query1_tag];
        query1_data  = data_q[query1_tag];
        query2_ready = ready_q[query2_tag];
        query2_data  = data_q[query2_tag];
        if (CDB_valid && (CDB_tag == query1_tag)) begin
            query1_ready = Valid;
            query1_data  = CDB_data;
        end
        if (CDB_valid && (CDB_tag == query2_tag)) begin
            query2_ready = Valid;
            query2_data  = CDB_data;
        end
    end
`else
    logic unused_query;
    assign unused_query = ^{query1_tag, query2_tag};
    assign query1_ready = Invalid;
    assign query1_data  = Null;
    assign query2_ready = Invalid;
    assign query2_data  = Null;
`endif

endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: directed scenarios then random traffic against a queue-based model.
// Query-port expectations follow ROB_BYPASS_EN in the same build.
module tb_reorder_buffer;

    logic        clk, rst, rdy;
    logic        ID_valid;
    logic [1:0]  ID_type;
    logic [4:0]  ID_reg_dest;
    logic [31:0] ID_pc;
    logic        ROB_full;
    logic [3:0]  ROB_next_tag;
    logic        CDB_valid;
    logic [3:0]  CDB_tag;
    logic [31:0] CDB_data;
    logic        CDB_mispredict;
    logic [31:0] CDB_target_pc;
    logic        ROB_data_valid;
    logic [4:0]  ROB_reg_dest;
    logic [3:0]  ROB_tag;
    logic [31:0] ROB_data;
    logic        LSB_commit_valid;
    logic [3:0]  LSB_commit_tag;
    logic        clear;
    logic [31:0] clear_pc;
    logic [3:0]  query1_tag, query2_tag;
    logic        query1_ready, query2_ready;
    logic [31:0] query1_data, query2_data;

    int total = 0;
    int bad   = 0;

    // Reference model: live tags in program order plus per-tag records.
    int          live[$];
    int          next_tag;
    int          m_type [16];
    int          m_dest [16];
    bit          m_ready[16];
    bit          m_mis  [16];
    logic [31:0] m_data [16];
    logic [31:0] m_tgt  [16];
    bit          exp_dv, exp_lsb, exp_clear;
    int          exp_dest, exp_tag, exp_lsbtag;
    logic [31:0] exp_data, exp_cpc;

    reorder_buffer dut (
        .clk              (clk),
        .rst              (rst),
        .rdy              (rdy),
        .ID_valid         (ID_valid),
        .ID_type          (ID_type),
        .ID_reg_dest      (ID_reg_dest),
        .ID_pc            (ID_pc),
        .ROB_full         (ROB_full),
        .ROB_next_tag     (ROB_next_tag),
        .CDB_valid        (CDB_valid),
        .CDB_tag          (CDB_tag),
        .CDB_data         (CDB_data),
        .CDB_mispredict   (CDB_mispredict),
        .CDB_target_pc    (CDB_target_pc),
        .ROB_data_valid   (ROB_data_valid),
        .ROB_reg_dest     (ROB_reg_dest),
        .ROB_tag          (ROB_tag),
        .ROB_data         (ROB_data),
        .LSB_commit_valid (LSB_commit_valid),
        .LSB_commit_tag   (LSB_commit_tag),
        .clear            (clear),
        .clear_pc         (clear_pc),
        .query1_tag       (query1_tag),
        .query1_ready     (query1_ready),
        .query1_data      (query1_data),
        .query2_tag       (query2_tag),
        .query2_ready     (query2_ready),
        .query2_data      (query2_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit is_live(input int t);
        foreach (live[i]) if (live[i] == t) return 1'b1;
        return 1'b0;
    endfunction

    task automatic reset_model();
        live.delete();
        next_tag  = 0;
        exp_dv    = 0;
        exp_lsb   = 0;
        exp_clear = 0;
        for (int i = 0; i < 16; i++) begin
            m_ready[i] = 0;
            m_mis[i]   = 0;
        end
    endtask

    task automatic model_edge(input bit r, input bit idv, input int ity, input int dst,
                              input bit cv, input int ctag, input logic [31:0] cdata,
                              input bit cmis, input logic [31:0] ctgt);
        bit clr_prev = exp_clear;
        int pre_size = live.size();
        bit do_flush = 0;
        int h;
        exp_dv    = 0;
        exp_lsb   = 0;
        exp_clear = 0;
        if (r && live.size() > 0 && m_ready[live[0]]) begin
            h = live.pop_front();
            if (m_type[h] == 2) begin
                exp_lsb    = 1;
                exp_lsbtag = h;
            end else begin
                exp_dv   = 1;
                exp_dest = m_dest[h];
                exp_tag  = h;
                exp_data = m_data[h];
            end
            if (m_type[h] == 1 && m_mis[h]) begin
                exp_clear = 1;
                exp_cpc   = m_tgt[h];
                do_flush  = 1;
            end
        end
        if (r && !clr_prev && cv) begin
            m_ready[ctag] = 1;
            m_data[ctag]  = cdata;
            m_mis[ctag]   = cmis;
            m_tgt[ctag]   = ctgt;
        end
        if (r && !clr_prev && idv && pre_size < 16) begin
            live.push_back(next_tag);
            m_type[next_tag]  = ity;
            m_dest[next_tag]  = dst;
            m_ready[next_tag] = 0;
            m_mis[next_tag]   = 0;
            next_tag          = (next_tag + 1) % 16;
        end
        if (do_flush) reset_model_keep_outputs();
    endtask

    task automatic reset_model_keep_outputs();
        live.delete();
        next_tag = 0;
        for (int i = 0; i < 16; i++) begin
            m_ready[i] = 0;
            m_mis[i]   = 0;
        end
    endtask

    task automatic qcheck(input string nm, input int q, input logic r_obs, input logic [31:0] d_obs,
                          input bit cv, input int ctag, input logic [31:0] cdata);
`ifdef ROB_BYPASS_EN
        if (cv && ctag == q) begin
            check({nm, "_ready_fwd"}, 32'(r_obs), 32'd1);
            check({nm, "_data_fwd"}, d_obs, cdata);
        end else if (is_live(q)) begin
            check({nm, "_ready"}, 32'(r_obs), 32'(m_ready[q]));
            if (m_ready[q]) check({nm, "_data"}, d_obs, m_data[q]);
        end
`else
        check({nm, "_ready_tied"}, 32'(r_obs), 32'd0);
        check({nm, "_data_tied"}, d_obs, 32'd0);
`endif
    endtask

    task automatic check_outputs();
        check("full", 32'(ROB_full), 32'(live.size() == 16));
        check("next_tag", 32'(ROB_next_tag), next_tag);
        check("data_valid", 32'(ROB_data_valid), 32'(exp_dv));
        if (exp_dv) begin
            check("reg_dest", 32'(ROB_reg_dest), exp_dest);
            check("rob_tag", 32'(ROB_tag), exp_tag);
            check("rob_data", ROB_data, exp_data);
        end
        check("lsb_valid", 32'(LSB_commit_valid), 32'(exp_lsb));
        if (exp_lsb) check("lsb_tag", 32'(LSB_commit_tag), exp_lsbtag);
        check("clear", 32'(clear), 32'(exp_clear));
        if (exp_clear) check("clear_pc", clear_pc, exp_cpc);
    endtask

    // One clock: drive at posedge+1, check queries combinationally, then check after the edge.
    task automatic step(input bit r, input bit idv, input int ity, input int dst,
                        input logic [31:0] pc, input bit cv, input int ctag,
                        input logic [31:0] cdata, input bit cmis, input logic [31:0] ctgt);
        rdy            = r;
        ID_valid       = idv;
        ID_type        = 2'(ity);
        ID_reg_dest    = 5'(dst);
        ID_pc          = pc;
        CDB_valid      = cv;
        CDB_tag        = 4'(ctag);
        CDB_data       = cdata;
        CDB_mispredict = cmis;
        CDB_target_pc  = ctgt;
        query1_tag     = cv ? 4'(ctag) : 4'($urandom_range(15));
        query2_tag     = 4'($urandom_range(15));
        #1;
        qcheck("q1", int'(query1_tag), query1_ready, query1_data, cv, ctag, cdata);
        qcheck("q2", int'(query2_tag), query2_ready, query2_data, cv, ctag, cdata);
        model_edge(r, idv, ity, dst, cv, ctag, cdata, cmis, ctgt);
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic idle();
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic alloc(input int ty, input int dst);
        step(1, 1, ty, dst, $urandom, 0, 0, 0, 0, 0);
    endtask

    task automatic complete(input int t, input logic [31:0] d, input bit mis, input logic [31:0] tg);
        step(1, 0, 0, 0, 0, 1, t, d, mis, tg);
    endtask

    task automatic drain();
        int tags[$];
        tags = live;
        foreach (tags[i]) begin
            if (is_live(tags[i]) && !m_ready[tags[i]]) complete(tags[i], $urandom, 0, 0);
        end
        repeat (20) idle();
    endtask

    // Asserts reset between edges and expects every output to drop at once.
    task automatic reset_dut();
        ID_valid  = 0;
        CDB_valid = 0;
        #2 rst = 0;
        #1;
        check("rst_data_valid", 32'(ROB_data_valid), 32'd0);
        check("rst_lsb_valid", 32'(LSB_commit_valid), 32'd0);
        check("rst_clear", 32'(clear), 32'd0);
        check("rst_full", 32'(ROB_full), 32'd0);
        check("rst_next_tag", 32'(ROB_next_tag), 32'd0);
        check("rst_rob_data", ROB_data, 32'd0);
        check("rst_rob_tag", 32'(ROB_tag), 32'd0);
        check("rst_reg_dest", 32'(ROB_reg_dest), 32'd0);
        check("rst_lsb_tag", 32'(LSB_commit_tag), 32'd0);
        check("rst_clear_pc", clear_pc, 32'd0);
        reset_model();
        #1 rst = 1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int t;
        rst = 1; rdy = 0; ID_valid = 0; ID_type = 0; ID_reg_dest = 0; ID_pc = 0;
        CDB_valid = 0; CDB_tag = 0; CDB_data = 0; CDB_mispredict = 0; CDB_target_pc = 0;
        query1_tag = 0; query2_tag = 0;
        reset_model();
        @(posedge clk);
        #1;
        reset_dut();

        // Out-of-order completion, in-order commit.
        alloc(0, 5); alloc(0, 6); alloc(0, 7);
        complete(2, 32'hA, 0, 0); complete(0, 32'hB, 0, 0); complete(1, 32'hC, 0, 0);
        repeat (3) idle();

        // Reset while a commit pulse is high and another entry is in flight.
        t = next_tag;
        alloc(0, 11); alloc(0, 12);
        complete(t, 32'h77, 0, 0);
        idle();
        check("commit_before_reset", 32'(ROB_data_valid), 32'd1);
        reset_dut();
        idle();

        // Fill, overflow attempt, commit with blocked alloc, then wrap-around reuse of tag 0.
        for (int i = 0; i < 16; i++) alloc(0, i + 1);
        alloc(0, 31);
        complete(0, 32'h100, 0, 0);
        alloc(0, 20);
        alloc(0, 21);
        complete(1, 32'h101, 0, 0);
        complete(2, 32'h102, 0, 0);
        alloc(0, 22);
        drain();

        // Mispredicted branch at tag 3 with younger tags 4-6 live.
        reset_dut();
        for (int i = 0; i < 7; i++) alloc((i == 3) ? 1 : 0, i + 1);
        complete(0, 32'h30, 0, 0); complete(1, 32'h31, 0, 0); complete(2, 32'h32, 0, 0);
        complete(3, 32'h33, 1, 32'h1000);
        step(1, 1, 0, 13, 0, 1, 4, 32'h44, 0, 0);
        check("flush_pc", clear_pc, 32'h1000);
        step(1, 1, 0, 14, 0, 1, 5, 32'h45, 0, 0);
        alloc(0, 15);

        // Store commit at tag 2.
        alloc(0, 16); alloc(2, 0);
        complete(0, 32'h50, 0, 0); complete(1, 32'h51, 0, 0); complete(2, 32'h52, 0, 0);
        repeat (3) idle();

        // Same-cycle query of tag 5 while it completes.
        alloc(0, 3); alloc(0, 4); alloc(0, 5);
        complete(5, 32'h55, 0, 0);
        drain();

        // Random traffic including stalls and occasional mispredicts.
        reset_dut();
        for (int n = 0; n < 600; n++) begin
            int cands[$];
            bit cv;
            int ct;
            cv = 0;
            ct = 0;
            foreach (live[i]) if (!m_ready[live[i]]) cands.push_back(live[i]);
            if (cands.size() > 0 && $urandom_range(1) == 1) begin
                cv = 1;
                ct = cands[$urandom_range(cands.size() - 1)];
            end
            step($urandom_range(9) != 0, $urandom_range(1) == 1, $urandom_range(2),
                 $urandom_range(31), $urandom, cv, ct, $urandom, $urandom_range(7) == 0,
                 $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
